// File: rtl/if_id_buffer_pkg.sv
// Shared definitions for the IF/ID stage: FSM states, default widths, bubble word and decode packet.
package pipe_pkg;

    localparam int INSTR_W_DEFAULT = 16;
    localparam int PC_W_DEFAULT    = 32;
    localparam int IMM_BIT_DEFAULT = 15;
    localparam logic [INSTR_W_DEFAULT-1:0] NOP_WORD_DEFAULT = 16'h0000;

    typedef enum logic {
        S_OP  = 1'b0,
        S_IMM = 1'b1
    } state_t;

    typedef struct packed {
        logic [INSTR_W_DEFAULT-1:0] instr;
        logic [INSTR_W_DEFAULT-1:0] imm;
        logic [PC_W_DEFAULT-1:0]    pc;
        logic                       valid;
    } if_id_pkt_t;

endpackage

// File: rtl/if_id_buffer_sat_counter.sv
// Up-counter that sticks at all-ones instead of wrapping.
// Latency: count visible the cycle after inc is sampled.
// Backpressure: none; inc is sampled every cycle, rst clears.
module sat_counter #(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         inc,
    output logic [W-1:0] cnt
);

    logic [W-1:0] cnt_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else if (inc && (cnt_q != '1)) begin
            cnt_q <= cnt_q + W'(1);
        end
    end

    assign cnt = cnt_q;

endmodule

// File: rtl/if_id_buffer.sv
// IF/ID pipeline register; joins opcode + immediate words into one decode packet.
// Latency: 1 cycle instr_in -> instr_out; two-word instructions emit a bubble while the opcode is held.
// Backpressure: Stall freezes all state and drops pc_write_en; flush beats Stall. Optional stall_cnt under IF_ID_STALL_COUNT_EN.
module if_id_buffer
    import pipe_pkg::*;
#(
    parameter int INSTR_W = INSTR_W_DEFAULT,
    parameter int PC_W    = PC_W_DEFAULT,
    parameter int IMM_BIT = IMM_BIT_DEFAULT,
    parameter logic [INSTR_W-1:0] NOP_WORD = INSTR_W'(NOP_WORD_DEFAULT)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [INSTR_W-1:0] instr_in,
    input  logic [PC_W-1:0]    pc_in,
    input  logic               valid_in,
    input  logic               Stall,
    input  logic               flush,
    output logic [INSTR_W-1:0] instr_out,
    output logic [INSTR_W-1:0] imm_out,
    output logic [PC_W-1:0]    pc_out,
    output logic               valid_out,
    output logic               pc_write_en,
    output logic               imm_pending
`ifdef IF_ID_STALL_COUNT_EN
    ,
    output logic [15:0]        stall_cnt
`endif
);

    state_t             state_q;
    logic [INSTR_W-1:0] instr_q;
    logic [INSTR_W-1:0] imm_q;
    logic [PC_W-1:0]    pc_q;
    logic               valid_q;
    logic [INSTR_W-1:0] hold_op_q;
    logic [PC_W-1:0]    hold_pc_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= S_OP;
            instr_q   <= NOP_WORD;
            imm_q     <= '0;
            pc_q      <= '0;
            valid_q   <= 1'b0;
            hold_op_q <= '0;
            hold_pc_q <= '0;
        end else if (flush) begin
            // Same as reset except pc_out, which keeps the last issued PC.
            state_q   <= S_OP;
            instr_q   <= NOP_WORD;
            imm_q     <= '0;
            valid_q   <= 1'b0;
            hold_op_q <= '0;
            hold_pc_q <= '0;
        end else if (!Stall) begin
            if (state_q == S_OP) begin
                if (valid_in && !instr_in[IMM_BIT]) begin
                    instr_q <= instr_in;
                    imm_q   <= '0;
                    pc_q    <= pc_in;
                    valid_q <= 1'b1;
                end else begin
                    instr_q <= NOP_WORD;
                    imm_q   <= '0;
                    valid_q <= 1'b0;
                    if (valid_in) begin
                        hold_op_q <= instr_in;
                        hold_pc_q <= pc_in;
                        state_q   <= S_IMM;
                    end
                end
            end else begin
                // The immediate word is data; its top bit carries no meaning here.
                if (valid_in) begin
                    instr_q <= hold_op_q;
                    imm_q   <= instr_in;
                    pc_q    <= hold_pc_q;
                    valid_q <= 1'b1;
                    state_q <= S_OP;
                end else begin
                    instr_q <= NOP_WORD;
                    imm_q   <= '0;
                    valid_q <= 1'b0;
                end
            end
        end
    end

    assign instr_out   = instr_q;
    assign imm_out     = imm_q;
    assign pc_out      = pc_q;
    assign valid_out   = valid_q;
    assign imm_pending = (state_q == S_IMM);
    assign pc_write_en = ~Stall;

`ifdef IF_ID_STALL_COUNT_EN
    sat_counter #(
        .W (16)
    ) u_stall_cnt (
        .clk (clk),
        .rst (rst),
        .inc (Stall),
        .cnt (stall_cnt)
    );
`endif

endmodule

// File: tb/tb_if_id_buffer.sv
// Directed bench for if_id_buffer: scoreboard of expected packets checked by an independent monitor.
module tb_if_id_buffer;
    import pipe_pkg::*;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [15:0] instr_in = '0;
    logic [31:0] pc_in = '0;
    logic        valid_in = 1'b0;
    logic        Stall = 1'b0;
    logic        flush = 1'b0;
    logic [15:0] instr_out;
    logic [15:0] imm_out;
    logic [31:0] pc_out;
    logic        valid_out;
    logic        pc_write_en;
    logic        imm_pending;
`ifdef IF_ID_STALL_COUNT_EN
    logic [15:0] stall_cnt;
`endif

    if_id_buffer dut (
        .clk         (clk),
        .rst         (rst),
        .instr_in    (instr_in),
        .pc_in       (pc_in),
        .valid_in    (valid_in),
        .Stall       (Stall),
        .flush       (flush),
        .instr_out   (instr_out),
        .imm_out     (imm_out),
        .pc_out      (pc_out),
        .valid_out   (valid_out),
        .pc_write_en (pc_write_en),
        .imm_pending (imm_pending)
`ifdef IF_ID_STALL_COUNT_EN
        ,
        .stall_cnt   (stall_cnt)
`endif
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;
    int cyc = 0;

    if_id_pkt_t exp_q[$];
    int         exp_cyc_q[$];
    if_id_pkt_t mon_pkt;
    int         mon_cyc;
    logic       edge_stall = 1'b0;
    logic       edge_rst = 1'b1;

    always @(posedge clk) begin
        cyc        <= cyc + 1;
        edge_stall <= Stall;
        edge_rst   <= rst;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    // Expected packet is due on the output the cycle after the coming edge.
    task automatic expect_pkt(input logic [15:0] i, input logic [15:0] im, input logic [31:0] p);
        if_id_pkt_t k;
        k.instr = i;
        k.imm   = im;
        k.pc    = p;
        k.valid = 1'b1;
        exp_q.push_back(k);
        exp_cyc_q.push_back(cyc + 1);
    endtask

    // A packet is new when the last edge was neither a reset nor a stall.
    always @(negedge clk) begin
        if (!edge_rst && !edge_stall && valid_out === 1'b1) begin
            if (exp_q.size() == 0) begin
                n_cmp++;
                n_bad++;
                $display("FAIL unexpected_pkt: got instr %h pc %h, expected no packet", instr_out, pc_out);
            end else begin
                mon_pkt = exp_q.pop_front();
                mon_cyc = exp_cyc_q.pop_front();
                check("pkt_instr", {16'h0, instr_out}, {16'h0, mon_pkt.instr});
                check("pkt_imm", {16'h0, imm_out}, {16'h0, mon_pkt.imm});
                check("pkt_pc", pc_out, mon_pkt.pc);
                check("pkt_cycle", cyc, mon_cyc);
            end
        end
    end

    task automatic drive(input logic [15:0] i, input logic [31:0] p, input logic v,
                         input logic s, input logic f, input logic r);
        instr_in = i;
        pc_in    = p;
        valid_in = v;
        Stall    = s;
        flush    = f;
        rst      = r;
        #1;
        check("pc_write_en", {31'h0, pc_write_en}, {31'h0, ~s});
        @(posedge clk);
        #1;
    endtask

    initial begin
        drive(16'h0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b1);
        drive(16'h0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b1);
        check("rst_instr", {16'h0, instr_out}, 32'h0);
        check("rst_imm", {16'h0, imm_out}, 32'h0);
        check("rst_pc", pc_out, 32'h0);
        check("rst_valid", {31'h0, valid_out}, 32'h0);
        check("rst_imm_pending", {31'h0, imm_pending}, 32'h0);

        // One-word instruction.
        expect_pkt(16'h1234, 16'h0, 32'h10);
        drive(16'h1234, 32'h10, 1'b1, 1'b0, 1'b0, 1'b0);

        // Two-word instruction back to back.
        drive(16'h8001, 32'h20, 1'b1, 1'b0, 1'b0, 1'b0);
        check("two_word_bubble_valid", {31'h0, valid_out}, 32'h0);
        check("two_word_bubble_instr", {16'h0, instr_out}, 32'h0);
        check("two_word_pending", {31'h0, imm_pending}, 32'h1);
        expect_pkt(16'h8001, 16'h00AB, 32'h20);
        drive(16'h00AB, 32'h22, 1'b1, 1'b0, 1'b0, 1'b0);
        check("two_word_done_pending", {31'h0, imm_pending}, 32'h0);

        // Gap between opcode and immediate; immediate has its top bit set.
        drive(16'h8002, 32'h30, 1'b1, 1'b0, 1'b0, 1'b0);
        drive(16'h0000, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0);
        check("imm_gap_valid", {31'h0, valid_out}, 32'h0);
        check("imm_gap_pending", {31'h0, imm_pending}, 32'h1);
        expect_pkt(16'h8002, 16'hFFFF, 32'h30);
        drive(16'hFFFF, 32'h32, 1'b1, 1'b0, 1'b0, 1'b0);

        // Three-cycle stall with a packet on the output.
        expect_pkt(16'h0042, 16'h0, 32'h40);
        drive(16'h0042, 32'h40, 1'b1, 1'b0, 1'b0, 1'b0);
        for (int k = 0; k < 3; k++) begin
            drive(16'h0077, 32'h42, 1'b1, 1'b1, 1'b0, 1'b0);
            check("stall_hold_instr", {16'h0, instr_out}, 32'h0042);
            check("stall_hold_pc", pc_out, 32'h40);
            check("stall_hold_valid", {31'h0, valid_out}, 32'h1);
        end
`ifdef IF_ID_STALL_COUNT_EN
        check("stall_cnt_3", {16'h0, stall_cnt}, 32'd3);
`endif
        expect_pkt(16'h0077, 16'h0, 32'h42);
        drive(16'h0077, 32'h42, 1'b1, 1'b0, 1'b0, 1'b0);

        // Stall while the opcode waits for its immediate.
        drive(16'h8003, 32'h50, 1'b1, 1'b0, 1'b0, 1'b0);
        drive(16'h00CC, 32'h52, 1'b1, 1'b1, 1'b0, 1'b0);
        check("stall_imm_pending", {31'h0, imm_pending}, 32'h1);
        check("stall_imm_bubble", {31'h0, valid_out}, 32'h0);
        expect_pkt(16'h8003, 16'h00CC, 32'h50);
        drive(16'h00CC, 32'h52, 1'b1, 1'b0, 1'b0, 1'b0);

        // Flush with Stall drops the half-built instruction and keeps pc_out.
        drive(16'h8001, 32'h60, 1'b1, 1'b0, 1'b0, 1'b0);
        drive(16'h00AB, 32'h62, 1'b1, 1'b1, 1'b1, 1'b0);
        check("flush_valid", {31'h0, valid_out}, 32'h0);
        check("flush_pending", {31'h0, imm_pending}, 32'h0);
        check("flush_instr", {16'h0, instr_out}, 32'h0);
        check("flush_pc_kept", pc_out, 32'h50);
        expect_pkt(16'h0005, 16'h0, 32'h64);
        drive(16'h0005, 32'h64, 1'b1, 1'b0, 1'b0, 1'b0);
`ifdef IF_ID_STALL_COUNT_EN
        check("stall_cnt_flush", {16'h0, stall_cnt}, 32'd5);
`endif

        // Reset in S_IMM with Stall high.
        drive(16'h8009, 32'h70, 1'b1, 1'b0, 1'b0, 1'b0);
        check("pre_rst_pending", {31'h0, imm_pending}, 32'h1);
        drive(16'h00DD, 32'h72, 1'b1, 1'b1, 1'b0, 1'b1);
        check("rst2_instr", {16'h0, instr_out}, 32'h0);
        check("rst2_imm", {16'h0, imm_out}, 32'h0);
        check("rst2_pc", pc_out, 32'h0);
        check("rst2_valid", {31'h0, valid_out}, 32'h0);
        check("rst2_pending", {31'h0, imm_pending}, 32'h0);
`ifdef IF_ID_STALL_COUNT_EN
        check("stall_cnt_rst", {16'h0, stall_cnt}, 32'd0);
        force dut.u_stall_cnt.cnt_q = 16'hFFFE;
        #1;
        release dut.u_stall_cnt.cnt_q;
        for (int k = 0; k < 4; k++) begin
            drive(16'h0, 32'h0, 1'b0, 1'b1, 1'b0, 1'b0);
            check("stall_cnt_sat", {16'h0, stall_cnt}, 32'h0000FFFF);
        end
`endif

        for (int k = 0; k < 3; k++) begin
            drive(16'h0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0);
        end
        check("scoreboard_empty", exp_q.size(), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
